// File: rtl/setting_pkg.sv
// Shared definitions for the front-panel settings block.
// Holds the field width, default ranges, the field index enum and helpers
// mapping a field to its up/down bit in the 6-bit button vector.
package setting_pkg;

  localparam int unsigned SETTING_W  = 3;
  localparam int unsigned NUM_FIELDS = 3;
  localparam int unsigned NUM_BTNS   = 2 * NUM_FIELDS;

  localparam int unsigned VOL_MIN_DEF   = 1;
  localparam int unsigned VOL_MAX_DEF   = 5;
  localparam int unsigned VOL_INIT_DEF  = 3;
  localparam int unsigned OCT_MIN_DEF   = 1;
  localparam int unsigned OCT_MAX_DEF   = 3;
  localparam int unsigned OCT_INIT_DEF  = 2;
  localparam int unsigned LOOP_MIN_DEF  = 1;
  localparam int unsigned LOOP_MAX_DEF  = 7;
  localparam int unsigned LOOP_INIT_DEF = 4;

  typedef logic [SETTING_W-1:0] setting_t;

  typedef enum logic [1:0] {
    FIELD_VOL  = 2'd0,
    FIELD_OCT  = 2'd1,
    FIELD_LOOP = 2'd2
  } field_e;

  // Button vector layout: bit 2*field is "up", bit 2*field+1 is "down".
  function automatic int unsigned btn_up_idx(field_e f);
    return {29'd0, f, 1'b0};
  endfunction

  function automatic int unsigned btn_dn_idx(field_e f);
    return {29'd0, f, 1'b1};
  endfunction

endpackage

// File: rtl/setting_input_controller_if.sv
// Settings/display bus: raw front-panel buttons in, registered settings out.
// master : the settings producer (buttons are inputs, settings are outputs)
// slave  : the consumer/panel side (drives buttons, reads settings)
interface setting_input_controller_if;
  import setting_pkg::*;

  logic     btn_vol_up;
  logic     btn_vol_down;
  logic     btn_oct_up;
  logic     btn_oct_down;
  logic     btn_loop_up;
  logic     btn_loop_down;
  setting_t volume;
  setting_t octave;
  setting_t loop_width;
  logic     setting_changed;

  modport master (
    input  btn_vol_up, btn_vol_down, btn_oct_up, btn_oct_down, btn_loop_up, btn_loop_down,
    output volume, octave, loop_width, setting_changed
  );

  modport slave (
    output btn_vol_up, btn_vol_down, btn_oct_up, btn_oct_down, btn_loop_up, btn_loop_down,
    input  volume, octave, loop_width, setting_changed
  );

endinterface

// File: rtl/button_conditioner.sv
// Per-button conditioner: 2-flop synchronizer, debounce, one-pulse press.
// Optional auto-repeat while held, enabled by SETTING_AUTO_REPEAT_EN.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   btn_raw_i raw button level, asynchronous to clk
//   press_o   one-cycle press pulse (plus repeat pulses when enabled)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef SETTING_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 2000,
  parameter int unsigned REPEAT_PERIOD   = 500
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [1:0]      prime_q, prime_d;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] arm_cnt_q, arm_cnt_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;
  logic            flip;
  logic            rise;

  always_comb begin
    // prime_q marks when sync2_q holds a real post-reset sample.
    prime_d  = {prime_q[0], 1'b1};
    flip     = 1'b0;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        flip     = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A button held through reset must be seen released before it may fire:
    // arm on an accepted release, or on a debounced-length run of real lows.
    armed_d   = armed_q;
    arm_cnt_d = '0;
    if (!armed_q) begin
      if (flip && stable_q) begin
        armed_d = 1'b1;
      end else if (prime_q[1] && !sync2_q && !stable_q) begin
        if (arm_cnt_q == CntLast) begin
          armed_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
    end

    rise = flip & ~stable_q & armed_q;
  end

`ifdef SETTING_AUTO_REPEAT_EN
  localparam int unsigned     RepW      = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RepW-1:0] RepLast   = RepW'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes later repeats land every PERIOD cycles.
  localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_fire;

  always_comb begin
    rep_fire  = 1'b0;
    rep_cnt_d = '0;
    if (stable_q && armed_q) begin
      if (rep_cnt_q == RepLast) begin
        rep_fire  = 1'b1;
        rep_cnt_d = RepReload;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign press_d = rise | rep_fire;
`else
  assign press_d = rise;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prime_q   <= '0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      prime_q   <= prime_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/setting_input_controller.sv
// Front-panel input block: conditions six push-buttons and maintains the
// saturating volume / octave / loop_width settings.
// Optional auto-repeat on held buttons: define SETTING_AUTO_REPEAT_EN.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  settings interface (master): raw buttons in; volume, octave,
//        loop_width and the setting_changed pulse out
module setting_input_controller import setting_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned VOL_MIN         = VOL_MIN_DEF,
  parameter int unsigned VOL_MAX         = VOL_MAX_DEF,
  parameter int unsigned VOL_INIT        = VOL_INIT_DEF,
  parameter int unsigned OCT_MIN         = OCT_MIN_DEF,
  parameter int unsigned OCT_MAX         = OCT_MAX_DEF,
  parameter int unsigned OCT_INIT        = OCT_INIT_DEF,
  parameter int unsigned LOOP_MIN        = LOOP_MIN_DEF,
  parameter int unsigned LOOP_MAX        = LOOP_MAX_DEF,
  parameter int unsigned LOOP_INIT       = LOOP_INIT_DEF,
  parameter int unsigned REPEAT_DELAY    = 2000,
  parameter int unsigned REPEAT_PERIOD   = 500
) (
  input logic                         clk,
  input logic                         rst,
  setting_input_controller_if.master  bus
);

  // Elaboration-time legality checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (!(VOL_MIN <= VOL_INIT && VOL_INIT <= VOL_MAX && VOL_MAX <= 7)) begin : g_bad_vol
    $error("volume range must satisfy MIN <= INIT <= MAX <= 7");
  end
  if (!(OCT_MIN <= OCT_INIT && OCT_INIT <= OCT_MAX && OCT_MAX <= 7)) begin : g_bad_oct
    $error("octave range must satisfy MIN <= INIT <= MAX <= 7");
  end
  if (!(LOOP_MIN <= LOOP_INIT && LOOP_INIT <= LOOP_MAX && LOOP_MAX <= 7)) begin : g_bad_loop
    $error("loop_width range must satisfy MIN <= INIT <= MAX <= 7");
  end
  if (REPEAT_PERIOD == 0 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
    $error("auto-repeat requires 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  typedef logic [NUM_FIELDS-1:0][SETTING_W-1:0] field_vec_t;

  localparam field_vec_t FieldMin  = {setting_t'(LOOP_MIN), setting_t'(OCT_MIN),
                                      setting_t'(VOL_MIN)};
  localparam field_vec_t FieldMax  = {setting_t'(LOOP_MAX), setting_t'(OCT_MAX),
                                      setting_t'(VOL_MAX)};
  localparam field_vec_t FieldInit = {setting_t'(LOOP_INIT), setting_t'(OCT_INIT),
                                      setting_t'(VOL_INIT)};

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;
  field_vec_t          val_q, val_d;
  logic                chg_pend_q, chg_pend_d;
  logic                setting_changed_q, setting_changed_d;

  assign btn_raw = {bus.btn_loop_down, bus.btn_loop_up,
                    bus.btn_oct_down,  bus.btn_oct_up,
                    bus.btn_vol_down,  bus.btn_vol_up};

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SETTING_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_cond (
      .clk       (clk),
      .rst       (rst),
      .btn_raw_i (btn_raw[b]),
      .press_o   (press[b])
    );
  end

  // Saturating up/down per field; opposing pulses in one cycle cancel.
  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    localparam int unsigned UpIdx = btn_up_idx(field_e'(f));
    localparam int unsigned DnIdx = btn_dn_idx(field_e'(f));
    logic inc, dec;

    assign inc = press[UpIdx] & ~press[DnIdx] & (val_q[f] < FieldMax[f]);
    assign dec = press[DnIdx] & ~press[UpIdx] & (val_q[f] > FieldMin[f]);
    assign val_d[f] = inc ? val_q[f] + 3'd1 :
                      dec ? val_q[f] - 3'd1 : val_q[f];
  end

  // The pulse trails the visible setting update by one cycle.
  always_comb begin
    chg_pend_d        = (val_d != val_q);
    setting_changed_d = chg_pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q             <= FieldInit;
      chg_pend_q        <= 1'b0;
      setting_changed_q <= 1'b0;
    end else begin
      val_q             <= val_d;
      chg_pend_q        <= chg_pend_d;
      setting_changed_q <= setting_changed_d;
    end
  end

  assign bus.volume          = val_q[FIELD_VOL];
  assign bus.octave          = val_q[FIELD_OCT];
  assign bus.loop_width      = val_q[FIELD_LOOP];
  assign bus.setting_changed = setting_changed_q;

endmodule

// File: tb/tb_setting_input_controller.sv
module tb_setting_input_controller;

  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 10;
  localparam int FMIN [3]  = '{1, 1, 1};
  localparam int FMAX [3]  = '{5, 3, 7};
  localparam int FINIT [3] = '{3, 2, 4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] btn = '0;  // vol_up, vol_dn, oct_up, oct_dn, loop_up, loop_dn

  setting_input_controller_if bus ();

  assign bus.btn_vol_up    = btn[0];
  assign bus.btn_vol_down  = btn[1];
  assign bus.btn_oct_up    = btn[2];
  assign bus.btn_oct_down  = btn[3];
  assign bus.btn_loop_up   = btn[4];
  assign bus.btn_loop_down = btn[5];

  setting_input_controller #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_val [3];
  bit m_chg;
  bit m_changed_last;
  bit m_live = 1'b0;
  bit d1 [6], d2 [6];
  bit runv [6];
  int runlen [6];
  bit acc [6];
  bit blocked [6];
  int lowrun [6];
  int held [6];
  bit pend [6];
  int age;

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int f = 0; f < 3; f++) m_val[f] = FINIT[f];
        m_chg = 1'b0;
        m_changed_last = 1'b0;
        age = 0;
        for (int b = 0; b < 6; b++) begin
          d1[b] = 1'b0; d2[b] = 1'b0; runv[b] = 1'b0; runlen[b] = 0; acc[b] = 1'b0;
          blocked[b] = 1'b1; lowrun[b] = 0; held[b] = 0; pend[b] = 1'b0;
        end
        m_live = 1'b1;
      end else begin
        m_chg = m_changed_last;
        m_changed_last = 1'b0;
        for (int f = 0; f < 3; f++) begin
          int nv;
          nv = m_val[f];
          if (pend[2*f] && !pend[2*f+1] && nv < FMAX[f]) nv = nv + 1;
          else if (pend[2*f+1] && !pend[2*f] && nv > FMIN[f]) nv = nv - 1;
          if (nv != m_val[f]) m_changed_last = 1'b1;
          m_val[f] = nv;
        end
        for (int b = 0; b < 6; b++) begin
          bit s, old, p;
          s = d2[b]; d2[b] = d1[b]; d1[b] = btn[b];
          p = 1'b0;
          // A level is accepted after DC consecutive identical synced samples.
          if (s == runv[b]) runlen[b]++;
          else begin runv[b] = s; runlen[b] = 1; end
`ifdef SETTING_AUTO_REPEAT_EN
          if (acc[b] && !blocked[b]) begin
            held[b]++;
            if (held[b] >= RD && (held[b] - RD) % RP == 0) p = 1'b1;
          end else begin
            held[b] = 0;
          end
`endif
          old = acc[b];
          if (runv[b] != acc[b] && runlen[b] >= DC) acc[b] = runv[b];
          if (!old && acc[b] && !blocked[b]) p = 1'b1;
          if (blocked[b]) begin
            if (old && !acc[b]) blocked[b] = 1'b0;
            else if (age >= 2 && !s && !old) begin
              lowrun[b]++;
              if (lowrun[b] == DC) blocked[b] = 1'b0;
            end else lowrun[b] = 0;
          end
          pend[b] = p;
        end
        age++;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("model_volume", int'(bus.volume), m_val[0]);
        check("model_octave", int'(bus.octave), m_val[1]);
        check("model_loop_width", int'(bus.loop_width), m_val[2]);
        check("model_setting_changed", int'(bus.setting_changed), int'(m_chg));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press buttons in mask for 8 cycles, release for 12; count change pulses.
  task automatic press(input logic [5:0] mask, output int pulses);
    pulses = 0;
    btn = btn | mask;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.setting_changed) pulses++;
    end
    btn = btn & ~mask;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.setting_changed) pulses++;
    end
  endtask

  initial begin : stim
    int p;
    btn = 6'b111111;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_volume", int'(bus.volume), 3);
    check("rst_octave", int'(bus.octave), 2);
    check("rst_loop_width", int'(bus.loop_width), 4);
    check("rst_setting_changed", int'(bus.setting_changed), 0);
    tick(12);
    btn = '0;
    tick(14);
    check("held_volume", int'(bus.volume), 3);
    check("held_octave", int'(bus.octave), 2);
    check("held_loop_width", int'(bus.loop_width), 4);

    // Clean press: update lands on the 7th edge after the raw edge.
    btn[0] = 1'b1;
    tick(6);
    check("lat_before", int'(bus.volume), 3);
    tick(1);
    check("lat_at", int'(bus.volume), 4);
    check("chg_not_yet", int'(bus.setting_changed), 0);
    tick(1);
    check("chg_pulse", int'(bus.setting_changed), 1);
    tick(1);
    check("chg_single", int'(bus.setting_changed), 0);
    tick(6);
    btn[0] = 1'b0;
    tick(12);
    check("no_second_change", int'(bus.volume), 4);

    // Bounce: 2-cycle toggles never reach the debounce length.
    for (int i = 0; i < 15; i++) begin
      btn[2] = (i % 2 == 0);
      tick(2);
    end
    btn[2] = 1'b1;
    tick(15);
    check("bounce_octave", int'(bus.octave), 3);
    btn[2] = 1'b0;
    tick(12);

    // Saturation on loop_width.
    for (int i = 0; i < 5; i++) begin
      press(6'b010000, p);
      check("sat_up_pulses", p, (i < 3) ? 1 : 0);
    end
    check("sat_up_value", int'(bus.loop_width), 7);
    for (int i = 0; i < 7; i++) begin
      press(6'b100000, p);
      check("sat_dn_pulses", p, (i < 6) ? 1 : 0);
    end
    check("sat_dn_value", int'(bus.loop_width), 1);

    // Simultaneous: vol up+down cancel, octave down applies.
    press(6'b001011, p);
    check("simul_pulses", p, 1);
    check("simul_volume", int'(bus.volume), 4);
    check("simul_octave", int'(bus.octave), 2);

`ifdef SETTING_AUTO_REPEAT_EN
    begin
      int t [4];
      int nchg;
      int prev;
      int k;
      press(6'b000001, p);
      check("rep_start_volume", int'(bus.volume), 5);
      btn[1] = 1'b1;
      prev = 5; k = 0; nchg = 0;
      for (int c = 1; c <= 80; c++) begin
        tick(1);
        if (int'(bus.volume) != prev) begin
          if (k < 4) t[k] = c;
          k++;
          prev = int'(bus.volume);
        end
        if (c > 48 && bus.setting_changed) nchg++;
      end
      btn[1] = 1'b0;
      tick(12);
      check("rep_steps", k, 4);
      check("rep_t0", t[0], 7);
      check("rep_t1", t[1], 27);
      check("rep_t2", t[2], 37);
      check("rep_t3", t[3], 47);
      check("rep_final", int'(bus.volume), 1);
      check("rep_no_more_chg", nchg, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
